frame_capture: RTL and testbench
================================

FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flops in each input synchronizer.
REQ-002 Parameter BYTE_W, default 8: bits per captured byte.
REQ-003 ti_clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 reg_length  input  32  expected bytes per FRAME-high window (one column).
REQ-006 reg_delay  input  32  expected columns per frame.
REQ-007 FRAME  input  1  asynchronous framing strobe from the transmitter; high while a column is sent.
REQ-008 CCLK  input  1  asynchronous serial bit clock; data is valid at its rising edge.
REQ-009 SDATA  input  1  asynchronous serial data, MSB first.
REQ-010 fifo_full  input  1  downstream FIFO full flag.
REQ-011 wr_en  output  1  one-cycle FIFO write strobe.
REQ-012 din  output  BYTE_W  captured byte; valid while wr_en=1.
REQ-013 write_byte_count  output  32  bytes written in the current frame.
REQ-014 frame_done  output  1  one-cycle pulse when reg_delay columns complete without error.
REQ-015 frame_err  output  1  sticky error flag.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FRAME, CCLK and SDATA SHALL each pass through a SYNC_STAGES-flop synchronizer, plus one history flop for edge detection on FRAME and CCLK.
REQ-018 A CCLK rising edge SHALL be counted only while synchronized FRAME=1; SDATA SHALL be shifted into a BYTE_W shift register MSB first on that cycle.
REQ-019 On the BYTE_W-th bit, din SHALL load the shift register and wr_en SHALL pulse the next cycle; total latency is SYNC_STAGES+2 ti_clk cycles from the first ti_clk edge that samples CCLK high to wr_en=1.
REQ-020 Each wr_en SHALL increment write_byte_count and the per-column byte counter by 1; counters SHALL be 32-bit and saturate at 2^32-1 (no wrap).
REQ-021 States: IDLE, ACTIVE, GAP, DONE, ERR.
REQ-022 IDLE -> ACTIVE on a FRAME rising edge; write_byte_count and column counter clear on this transition.
REQ-023 ACTIVE -> GAP on a FRAME falling edge when the column byte count = reg_length and the bit counter = 0; column counter increments.
REQ-024 GAP -> ACTIVE on a FRAME rising edge; GAP -> DONE when the column counter = reg_delay.
REQ-025 DONE SHALL pulse frame_done for exactly one cycle, then return to IDLE.
REQ-026 Any state -> ERR when: FRAME falls with byte count != reg_length or with a partial byte; byte count exceeds reg_length while in ACTIVE; fifo_full=1 on a cycle where wr_en would assert (byte dropped, wr_en held 0).
REQ-027 ERR SHALL set frame_err, keep wr_en low, and return to IDLE after FRAME has been low for one synchronized cycle; frame_err stays set until rst.
REQ-028 reg_length=0 or reg_delay=0 SHALL be treated as a configuration error: the first FRAME rising edge goes to ERR.
REQ-029 A CCLK edge in the same synchronized cycle as a FRAME falling edge SHALL be ignored.
REQ-030 reg_length and reg_delay SHALL be latched on IDLE->ACTIVE; changes mid-frame have no effect.

Reset
REQ-031 On rst: state=IDLE; wr_en=0, din=0, write_byte_count=0, frame_done=0, frame_err=0, busy=0; synchronizers, history flops, shift register and all counters = 0.
REQ-032 rst asserted mid-frame SHALL abandon the frame with no wr_en or frame_done pulse after the reset cycle.

Structure
REQ-033 State encoding and BYTE_W default SHALL live in the shared package frame_pkg, which also holds the Frame_State encodings.
REQ-034 One sub-module, frame_sync_edge (synchronizer + rise/fall detect), SHALL be instantiated once each for FRAME and CCLK; SDATA uses a plain synchronizer of equal depth.

Verification
REQ-035 reg_length=6, reg_delay=3; 18 bytes 0x01..0x12, CCLK=ti_clk/10 -> 18 wr_en pulses, din in order, write_byte_count=18, one frame_done, frame_err=0.
REQ-036 Column truncated to 5 bytes -> ERR at FRAME fall, frame_err=1, no frame_done, 5 wr_en pulses.
REQ-037 fifo_full=1 during byte 4 -> byte 4 not written, frame_err=1, no further wr_en in that frame.
REQ-038 FRAME falls after 3 bits of byte 2 -> frame_err=1; rst -> all outputs at reset values next cycle.
REQ-039 rst asserted after byte 9 -> no wr_en after reset; next clean frame completes with frame_done and count 18.
REQ-040 reg_length=0 -> first FRAME rise -> frame_err=1, zero wr_en pulses.

Source files
------------

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared state encoding, widths and helpers for the frame capture block
package frame_pkg;

   localparam int BYTE_W_DEFAULT = 8;
   localparam int CNT_W          = 32;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACTIVE = 3'd1,
      ST_GAP    = 3'd2,
      ST_DONE   = 3'd3,
      ST_ERR    = 3'd4
   } frame_state_e;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/frame_sync_edge.sv
// rtl/frame_sync_edge.sv - multi-flop synchronizer with rise/fall detection
module frame_sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic d_sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              hist_q, hist_d;

   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = d_async;
      hist_d    = sync_q[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign d_sync = sync_q[STAGES-1];
   assign rise   = d_sync & ~hist_q;
   assign fall   = ~d_sync & hist_q;

endmodule

// File: rtl/frame_capture.sv
// rtl/frame_capture.sv - captures serial bytes framed by FRAME/CCLK into a FIFO write stream
module frame_capture
   import frame_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int BYTE_W      = BYTE_W_DEFAULT
) (
   input  logic              ti_clk,
   input  logic              rst,
   input  logic [31:0]       reg_length,
   input  logic [31:0]       reg_delay,
   input  logic              FRAME,
   input  logic              CCLK,
   input  logic              SDATA,
   input  logic              fifo_full,
   output logic              wr_en,
   output logic [BYTE_W-1:0] din,
   output logic [31:0]       write_byte_count,
   output logic              frame_done,
   output logic              frame_err,
   output logic              busy
);

   localparam int               BIT_W    = $clog2(BYTE_W + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BYTE_W - 1);

   frame_state_e state_q, state_d;

   logic frame_sync, frame_rise, frame_fall;
   logic cclk_rise, cclk_sync_unused, cclk_fall_unused;

   logic [SYNC_STAGES-1:0] sdata_q, sdata_d;
   logic                   sdata_sync;

   logic [BYTE_W-1:0] shift_q, shift_d;
   logic [BYTE_W-1:0] din_q, din_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              byte_rdy_q, byte_rdy_d;
   logic              wr_pend_q, wr_pend_d;
   logic              wr_en_q, wr_en_d;
   logic [CNT_W-1:0]  wcount_q, wcount_d;
   logic [CNT_W-1:0]  col_bytes_q, col_bytes_d;
   logic [CNT_W-1:0]  col_cnt_q, col_cnt_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  delay_q, delay_d;
   logic              err_q, err_d;

   logic capture, byte_end, wr_go;

   frame_sync_edge #(.STAGES(SYNC_STAGES)) u_frame_sync (
      .clk     (ti_clk),
      .rst     (rst),
      .d_async (FRAME),
      .d_sync  (frame_sync),
      .rise    (frame_rise),
      .fall    (frame_fall)
   );

   frame_sync_edge #(.STAGES(SYNC_STAGES)) u_cclk_sync (
      .clk     (ti_clk),
      .rst     (rst),
      .d_async (CCLK),
      .d_sync  (cclk_sync_unused),
      .rise    (cclk_rise),
      .fall    (cclk_fall_unused)
   );

   assign sdata_sync = sdata_q[SYNC_STAGES-1];

   // frame_sync is already low on the fall cycle, so a coincident CCLK edge drops out here.
   assign capture  = (state_q == ST_ACTIVE) && frame_sync && cclk_rise;
   assign byte_end = capture && (bit_cnt_q == LAST_BIT);
   assign wr_go    = wr_pend_q && (state_q == ST_ACTIVE);

   always_ff @(posedge ti_clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_rise)
               state_d = (reg_length == '0 || reg_delay == '0) ? ST_ERR : ST_ACTIVE;
         end
         ST_ACTIVE: begin
            if (frame_fall)
               state_d = (col_bytes_q == len_q && bit_cnt_q == '0) ? ST_GAP : ST_ERR;
            else if (col_bytes_q > len_q || (wr_go && fifo_full))
               state_d = ST_ERR;
         end
         ST_GAP: begin
            if (col_cnt_q == delay_q) state_d = ST_DONE;
            else if (frame_rise)      state_d = ST_ACTIVE;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR: begin
            if (!frame_sync) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_IDLE);
      frame_done = (state_q == ST_DONE);
   end

   always_comb begin
      sdata_d     = sdata_q << 1;
      sdata_d[0]  = SDATA;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      din_d       = din_q;
      byte_rdy_d  = byte_end;
      wr_pend_d   = byte_rdy_q;
      wr_en_d     = wr_go && !fifo_full;
      wcount_d    = wcount_q;
      col_bytes_d = col_bytes_q;
      col_cnt_d   = col_cnt_q;
      len_d       = len_q;
      delay_d     = delay_q;
      err_d       = err_q || (state_d == ST_ERR);

      if (capture) begin
         shift_d   = {shift_q[BYTE_W-2:0], sdata_sync};
         bit_cnt_d = byte_end ? '0 : bit_cnt_q + 1'b1;
      end
      if (byte_rdy_q) din_d = shift_q;
      if (wr_en_d) begin
         wcount_d    = sat_inc(wcount_q);
         col_bytes_d = sat_inc(col_bytes_q);
      end

      if (state_q == ST_ACTIVE && state_d == ST_GAP)
         col_cnt_d = sat_inc(col_cnt_q);
      if (state_q != ST_ACTIVE && state_d == ST_ACTIVE) begin
         col_bytes_d = '0;
         bit_cnt_d   = '0;
         shift_d     = '0;
      end
      // Configuration is frozen for the whole frame at its first column.
      if (state_q == ST_IDLE && state_d == ST_ACTIVE) begin
         wcount_d  = '0;
         col_cnt_d = '0;
         len_d     = reg_length;
         delay_d   = reg_delay;
      end
   end

   always_ff @(posedge ti_clk) begin
      if (rst) begin
         sdata_q     <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         din_q       <= '0;
         byte_rdy_q  <= 1'b0;
         wr_pend_q   <= 1'b0;
         wr_en_q     <= 1'b0;
         wcount_q    <= '0;
         col_bytes_q <= '0;
         col_cnt_q   <= '0;
         len_q       <= '0;
         delay_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         sdata_q     <= sdata_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         din_q       <= din_d;
         byte_rdy_q  <= byte_rdy_d;
         wr_pend_q   <= wr_pend_d;
         wr_en_q     <= wr_en_d;
         wcount_q    <= wcount_d;
         col_bytes_q <= col_bytes_d;
         col_cnt_q   <= col_cnt_d;
         len_q       <= len_d;
         delay_q     <= delay_d;
         err_q       <= err_d;
      end
   end

   assign wr_en            = wr_en_q;
   assign din              = din_q;
   assign write_byte_count = wcount_q;
   assign frame_err        = err_q;

endmodule

// File: tb/tb_frame_capture.sv
// tb/tb_frame_capture.sv - directed self-checking bench for frame_capture
module tb_frame_capture;

   localparam int BW = 8;
   localparam int SS = 2;

   logic          ti_clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   reg_length = 32'd6;
   logic [31:0]   reg_delay = 32'd3;
   logic          FRAME = 1'b0, CCLK = 1'b0, SDATA = 1'b0, fifo_full = 1'b0;
   logic          wr_en;
   logic [BW-1:0] din;
   logic [31:0]   write_byte_count;
   logic          frame_done, frame_err, busy;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_rise = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   logic [BW-1:0] cap_q[$];
   int            lat_q[$];

   frame_capture #(.SYNC_STAGES(SS), .BYTE_W(BW)) dut (
      .ti_clk           (ti_clk),
      .rst              (rst),
      .reg_length       (reg_length),
      .reg_delay        (reg_delay),
      .FRAME            (FRAME),
      .CCLK             (CCLK),
      .SDATA            (SDATA),
      .fifo_full        (fifo_full),
      .wr_en            (wr_en),
      .din              (din),
      .write_byte_count (write_byte_count),
      .frame_done       (frame_done),
      .frame_err        (frame_err),
      .busy             (busy)
   );

   always #5 ti_clk = ~ti_clk;
   always @(posedge ti_clk) cyc <= cyc + 1;

   always @(negedge ti_clk) begin
      if (wr_en) begin
         wr_cnt = wr_cnt + 1;
         cap_q.push_back(din);
         lat_q.push_back(cyc - last_rise);
      end
      if (frame_done) done_cnt = done_cnt + 1;
   end

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge ti_clk);
   endtask

   task automatic clear_mon();
      wr_cnt   = 0;
      done_cnt = 0;
      cap_q.delete();
      lat_q.delete();
   endtask

   task automatic send_bit(input logic b);
      SDATA = b;
      tick(5);
      CCLK      = 1'b1;
      last_rise = cyc + 1;
      tick(5);
      CCLK = 1'b0;
   endtask

   task automatic send_byte(input logic [BW-1:0] v, input int nbits);
      for (int i = BW - 1; i >= BW - nbits; i--) send_bit(v[i]);
   endtask

   task automatic send_column(input int first, input int nbytes, input int partial);
      FRAME = 1'b1;
      tick(3);
      for (int i = 0; i < nbytes; i++) send_byte(BW'(first + i), BW);
      if (partial > 0) send_byte(BW'(first + nbytes), partial);
      tick(6);
      FRAME = 1'b0;
      tick(8);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      FRAME = 1'b0;
      CCLK  = 1'b0;
      SDATA = 1'b0;
      fifo_full = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(2);
      clear_mon();
   endtask

   task automatic check_reset_outputs(input string pfx);
      expect_eq({pfx, "_wr_en"}, 32'(wr_en), 32'd0);
      expect_eq({pfx, "_din"}, 32'(din), 32'd0);
      expect_eq({pfx, "_count"}, write_byte_count, 32'd0);
      expect_eq({pfx, "_done"}, 32'(frame_done), 32'd0);
      expect_eq({pfx, "_err"}, 32'(frame_err), 32'd0);
      expect_eq({pfx, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic check_clean_frame(input string pfx);
      expect_eq({pfx, "_wr_pulses"}, 32'(wr_cnt), 32'd18);
      for (int i = 0; i < 18; i++)
         expect_eq({pfx, "_din_order"}, (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hDEAD,
                   32'(i + 1));
      expect_eq({pfx, "_count"}, write_byte_count, 32'd18);
      expect_eq({pfx, "_done_pulses"}, 32'(done_cnt), 32'd1);
      expect_eq({pfx, "_err"}, 32'(frame_err), 32'd0);
      expect_eq({pfx, "_busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      tick(3);
      check_reset_outputs("reset");
      do_reset();

      // clean 6x3 frame
      for (int c = 0; c < 3; c++) send_column(1 + 6 * c, 6, 0);
      tick(10);
      check_clean_frame("clean");
      expect_eq("latency", (lat_q.size() > 0) ? 32'(lat_q[0]) : 32'hDEAD, 32'(SS + 2));

      // short column
      do_reset();
      send_column(1, 5, 0);
      tick(4);
      expect_eq("short_wr_pulses", 32'(wr_cnt), 32'd5);
      expect_eq("short_err", 32'(frame_err), 32'd1);
      expect_eq("short_done", 32'(done_cnt), 32'd0);

      // fifo_full while byte 4 completes
      do_reset();
      FRAME = 1'b1;
      tick(3);
      for (int i = 1; i <= 3; i++) send_byte(BW'(i), BW);
      fifo_full = 1'b1;
      send_byte(8'h04, BW);
      tick(2);
      fifo_full = 1'b0;
      send_byte(8'h05, BW);
      send_byte(8'h06, BW);
      tick(6);
      FRAME = 1'b0;
      tick(8);
      expect_eq("full_wr_pulses", 32'(wr_cnt), 32'd3);
      expect_eq("full_last_din", (cap_q.size() > 0) ? 32'(cap_q[cap_q.size() - 1]) : 32'hDEAD,
                32'h03);
      expect_eq("full_err", 32'(frame_err), 32'd1);
      expect_eq("full_done", 32'(done_cnt), 32'd0);

      // partial byte at FRAME fall, then reset
      do_reset();
      send_column(1, 1, 3);
      tick(4);
      expect_eq("partial_wr_pulses", 32'(wr_cnt), 32'd1);
      expect_eq("partial_err", 32'(frame_err), 32'd1);
      rst = 1'b1;
      tick(1);
      check_reset_outputs("partial_rst");
      rst = 1'b0;
      tick(2);

      // reset mid-frame after byte 9, then a clean frame
      do_reset();
      send_column(1, 6, 0);
      FRAME = 1'b1;
      tick(3);
      for (int i = 7; i <= 9; i++) send_byte(BW'(i), BW);
      tick(2);
      expect_eq("midrst_pre_pulses", 32'(wr_cnt), 32'd9);
      rst   = 1'b1;
      FRAME = 1'b0;
      CCLK  = 1'b0;
      tick(1);
      clear_mon();
      tick(1);
      rst = 1'b0;
      tick(30);
      expect_eq("midrst_post_pulses", 32'(wr_cnt), 32'd0);
      expect_eq("midrst_post_done", 32'(done_cnt), 32'd0);
      clear_mon();
      for (int c = 0; c < 3; c++) send_column(1 + 6 * c, 6, 0);
      tick(10);
      check_clean_frame("after_rst");

      // zero length is a configuration error
      do_reset();
      reg_length = 32'd0;
      send_column(1, 2, 0);
      tick(4);
      expect_eq("cfg_err", 32'(frame_err), 32'd1);
      expect_eq("cfg_wr_pulses", 32'(wr_cnt), 32'd0);
      expect_eq("cfg_done", 32'(done_cnt), 32'd0);
      expect_eq("cfg_busy_after", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
